// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding logic.
package mips_pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic             rfen;
        logic             load;
        logic [REG_W-1:0] dest;
    } shadow_slot_t;

    // True when a used, nonzero source register is produced by this slot.
    function automatic logic slot_hit(input shadow_slot_t s, input logic [REG_W-1:0] r,
                                      input logic uses);
        return uses && (r != '0) && s.valid && s.rfen && (s.dest == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// Per-operand forwarding priority matcher (EX > MEM > WB > RF); flags load-use on EX loads.
module hazard_fwd_select
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0] i_reg,
    input  logic             i_uses,
    input  shadow_slot_t     i_ex,
    input  shadow_slot_t     i_mem,
    input  shadow_slot_t     i_wb,
    output logic [1:0]       o_sel,
    output logic             o_load_use
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    always_comb begin
        w_ex_hit   = slot_hit(i_ex, i_reg, i_uses);
        w_mem_hit  = slot_hit(i_mem, i_reg, i_uses);
        w_wb_hit   = slot_hit(i_wb, i_reg, i_uses);
        o_sel      = FWD_RF;
        o_load_use = 1'b0;
        // Load data is not ready at EX output, so an EX load match stalls instead of forwarding.
        if (w_ex_hit) begin
            if (i_ex.load) o_load_use = 1'b1;
            else           o_sel      = FWD_EX;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// 5-stage MIPS hazard controller: shadow EX/MEM/WB slots, forwarding selects,
// load-use and HI/LO mult/div stalls.
module pipeline_hazard_controller #(
    parameter int REG_W         = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_RS,
    input  logic [REG_W-1:0] ID_RT,
    input  logic             ID_USES_RS,
    input  logic             ID_USES_RT,
    input  logic [REG_W-1:0] ID_DEST,
    input  logic             ID_RF_ENABLE,
    input  logic             ID_LOAD_INSTR,
    input  logic             ID_MULDIV,
    input  logic             ID_HILO_READ,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_BUBBLE,
    output logic [1:0]       FWD_A_SEL,
    output logic [1:0]       FWD_B_SEL,
    output logic             MULDIV_BUSY
);
    import mips_pipe_pkg::*;

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES);

    shadow_slot_t r_ex;
    shadow_slot_t r_mem;
    shadow_slot_t r_wb;
    shadow_slot_t w_id_slot;
    logic [3:0]   r_md_count;

    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic       w_lu_a;
    logic       w_lu_b;
    logic       w_load_use;
    logic       w_busy;
    logic       w_hilo_stall;
    logic       w_stall;
    logic       w_dest_nz;

    hazard_fwd_select u_fwd_a (
        .i_reg      (ID_RS),
        .i_uses     (ID_USES_RS),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_a),
        .o_load_use (w_lu_a)
    );

    hazard_fwd_select u_fwd_b (
        .i_reg      (ID_RT),
        .i_uses     (ID_USES_RT),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_b),
        .o_load_use (w_lu_b)
    );

    always_comb begin
        w_dest_nz       = (ID_DEST != '0);
        // Writes to $0 are recorded as non-writing so $0 never forwards or stalls.
        w_id_slot.valid = 1'b1;
        w_id_slot.rfen  = ID_RF_ENABLE & w_dest_nz;
        w_id_slot.load  = ID_LOAD_INSTR & w_dest_nz;
        w_id_slot.dest  = ID_DEST;
    end

    always_comb begin
        w_load_use   = w_lu_a | w_lu_b;
        w_busy       = (r_md_count != '0);
        w_hilo_stall = w_busy & (ID_HILO_READ | ID_MULDIV);
        w_stall      = w_load_use | w_hilo_stall;

        PC_LE        = Reset | ~w_stall;
        IF_ID_LE     = Reset | ~w_stall;
        ID_EX_BUBBLE = ~Reset & w_stall;
        FWD_A_SEL    = Reset ? FWD_RF : w_sel_a;
        FWD_B_SEL    = Reset ? FWD_RF : w_sel_b;
        MULDIV_BUSY  = ~Reset & w_busy;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_md_count <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_stall ? shadow_slot_t'('0) : w_id_slot;
            // A stalled mult/div keeps counting down the older op; it reloads only when it advances.
            if (ID_MULDIV && !w_stall)
                r_md_count <= MD_LOAD;
            else if (r_md_count != '0)
                r_md_count <= r_md_count - 4'd1;
        end
    end

endmodule
